// File: rtl/plic_target_arb_pkg.sv
// Shared constants and types for the PLIC per-target arbiter.
//   PLIC_IRQ_NUM    : default number of source slots (source 0 reserved)
//   PLIC_PRIO_WIDTH : default width of priority and threshold fields
//   PLIC_ID_WIDTH   : width of a source ID at the default slot count
//   state_e         : arbiter FSM encoding (IDLE=0, SCAN=1)
package plic_target_arb_pkg;
  localparam int PLIC_IRQ_NUM    = 32;
  localparam int PLIC_PRIO_WIDTH = 3;
  localparam int PLIC_ID_WIDTH   = $clog2(PLIC_IRQ_NUM);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;
endpackage

// File: rtl/plic_prio_sel.sv
// Single-source evaluation: a source is a candidate when pending, enabled
// and of nonzero priority; it replaces the running best only when strictly
// greater, so equal priorities keep the earlier (lower) ID.
// Ports: i_ip, i_ie, i_prio, i_best_prio -> o_upd
module plic_prio_sel #(
  parameter int PRIO_WIDTH = 3
) (
  input  logic                  i_ip,
  input  logic                  i_ie,
  input  logic [PRIO_WIDTH-1:0] i_prio,
  input  logic [PRIO_WIDTH-1:0] i_best_prio,
  output logic                  o_upd
);
  logic w_cand;
  assign w_cand = i_ip & i_ie & (i_prio != '0);
  assign o_upd  = w_cand & (i_prio > i_best_prio);
endmodule

// File: rtl/register.sv
// Shared flop cells.
//   dffr  : async active-low reset flop, reset value RST
//   dfflr : same, with load enable i_en (holds when i_en=0)
// Ports: i_clk, i_rst_n, [i_en], i_d[W-1:0] -> o_q[W-1:0]
module dffr #(
  parameter int           W   = 1,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) o_q <= RST;
    else          o_q <= i_d;
endmodule

module dfflr #(
  parameter int           W   = 1,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n)  o_q <= RST;
    else if (i_en) o_q <= i_d;
endmodule

// File: rtl/plic_target_arb.sv
// Per-target PLIC arbiter. Sweeps sources 1..IRQ_NUM-1 one per cycle,
// tracking the highest-priority pending+enabled source, and publishes the
// winner (ID, priority, meip) at the end of each free-running sweep.
// Ports:
//   clk_i, rst_n_i          clock, async active-low reset
//   ip_i, ie_i              pending / enable vectors (bit 0 ignored)
//   prio_i                  packed priorities, source i at [i*PW +: PW]
//   thold_i                 target threshold
//   claim_i                 claim accepted: clear outputs, restart sweep
//   max_id_o, max_prio_o    published winner (0 = none)
//   irq_o                   meip to the hart
//   sweep_done_o            one-cycle pulse on publish
// Build option: PLIC_TARGET_ARB_RECHECK_EN -- drop a published winner as
// soon as its pending or enable bit falls, without waiting for a sweep.
import plic_target_arb_pkg::*;

module plic_target_arb #(
  parameter  int IRQ_NUM    = PLIC_IRQ_NUM,
  parameter  int PRIO_WIDTH = PLIC_PRIO_WIDTH,
  localparam int ID_WIDTH   = $clog2(IRQ_NUM)
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [IRQ_NUM-1:0]            ip_i,
  input  logic [IRQ_NUM-1:0]            ie_i,
  input  logic [IRQ_NUM*PRIO_WIDTH-1:0] prio_i,
  input  logic [PRIO_WIDTH-1:0]         thold_i,
  input  logic                          claim_i,
  output logic [ID_WIDTH-1:0]           max_id_o,
  output logic [PRIO_WIDTH-1:0]         max_prio_o,
  output logic                          irq_o,
  output logic                          sweep_done_o
);
  localparam logic [ID_WIDTH-1:0] LAST = ID_WIDTH'(IRQ_NUM-1);
  localparam logic [ID_WIDTH-1:0] ONE  = ID_WIDTH'(1);

  logic                  r_state_bit;
  state_e                w_state, w_state_d;
  logic [ID_WIDTH-1:0]   r_idx, w_idx_d;
  logic [ID_WIDTH-1:0]   r_bid, w_bid_d;
  logic [PRIO_WIDTH-1:0] r_bprio, w_bprio_d;
  logic [ID_WIDTH-1:0]   r_max_id, w_id_d;
  logic [PRIO_WIDTH-1:0] r_max_prio, w_prio_d;
  logic                  r_irq, w_irq_d;
  logic                  r_done, w_done_d;
  logic                  w_out_ld;
  logic [PRIO_WIDTH-1:0] w_cur_prio;
  logic                  w_upd;
  logic [ID_WIDTH-1:0]   w_fin_id;
  logic [PRIO_WIDTH-1:0] w_fin_prio;

  assign w_state    = state_e'(r_state_bit);
  assign w_cur_prio = prio_i[int'(r_idx)*PRIO_WIDTH +: PRIO_WIDTH];

  plic_prio_sel #(.PRIO_WIDTH(PRIO_WIDTH)) u_sel (
    .i_ip        (ip_i[r_idx]),
    .i_ie        (ie_i[r_idx]),
    .i_prio      (w_cur_prio),
    .i_best_prio (r_bprio),
    .o_upd       (w_upd)
  );

  // Final result with the last source folded in.
  assign w_fin_id   = w_upd ? r_idx      : r_bid;
  assign w_fin_prio = w_upd ? w_cur_prio : r_bprio;

  always_comb begin
    w_state_d = w_state;
    w_idx_d   = r_idx;
    w_bid_d   = r_bid;
    w_bprio_d = r_bprio;
    w_out_ld  = 1'b0;
    w_id_d    = '0;
    w_prio_d  = '0;
    w_irq_d   = 1'b0;
    w_done_d  = 1'b0;
    if (claim_i) begin
      // Claim beats a coinciding publish: the claimed ID must not reappear.
      w_state_d = IDLE;
      w_idx_d   = ONE;
      w_bid_d   = '0;
      w_bprio_d = '0;
      w_out_ld  = 1'b1;
    end else if (w_state == IDLE) begin
      w_state_d = SCAN;
      w_idx_d   = ONE;
      w_bid_d   = '0;
      w_bprio_d = '0;
    end else if (r_idx == LAST) begin
      w_out_ld  = 1'b1;
      w_id_d    = w_fin_id;
      w_prio_d  = w_fin_prio;
      w_irq_d   = w_fin_prio > thold_i;
      w_done_d  = 1'b1;
      w_idx_d   = ONE;
      w_bid_d   = '0;
      w_bprio_d = '0;
    end else begin
      w_idx_d = r_idx + ONE;
      if (w_upd) begin
        w_bid_d   = r_idx;
        w_bprio_d = w_cur_prio;
      end
    end
`ifdef PLIC_TARGET_ARB_RECHECK_EN
    // Winner lost pending/enable: retract it (loads zeros).
    if (!w_out_ld && (r_max_id != '0) && !(ip_i[r_max_id] & ie_i[r_max_id]))
      w_out_ld = 1'b1;
`endif
  end

  dffr #(.W(1), .RST(1'b0)) u_state (
    .i_clk(clk_i), .i_rst_n(rst_n_i), .i_d(w_state_d), .o_q(r_state_bit));
  dffr #(.W(ID_WIDTH), .RST(ONE)) u_idx (
    .i_clk(clk_i), .i_rst_n(rst_n_i), .i_d(w_idx_d), .o_q(r_idx));
  dffr #(.W(ID_WIDTH)) u_bid (
    .i_clk(clk_i), .i_rst_n(rst_n_i), .i_d(w_bid_d), .o_q(r_bid));
  dffr #(.W(PRIO_WIDTH)) u_bprio (
    .i_clk(clk_i), .i_rst_n(rst_n_i), .i_d(w_bprio_d), .o_q(r_bprio));
  dfflr #(.W(ID_WIDTH+PRIO_WIDTH+1)) u_out (
    .i_clk(clk_i), .i_rst_n(rst_n_i), .i_en(w_out_ld),
    .i_d({w_id_d, w_prio_d, w_irq_d}), .o_q({r_max_id, r_max_prio, r_irq}));
  dffr #(.W(1)) u_done (
    .i_clk(clk_i), .i_rst_n(rst_n_i), .i_d(w_done_d), .o_q(r_done));

  assign max_id_o     = r_max_id;
  assign max_prio_o   = r_max_prio;
  assign irq_o        = r_irq;
  assign sweep_done_o = r_done;
endmodule
